// File: rtl/code_lock_param.sv
// Parametrised keypad code lock.
// Compares a CODE_LEN-digit key sequence against a reprogrammable code register,
// abandons idle partial entries, locks out after MAX_TRIES consecutive bad codes,
// and shows status on a 7-segment display (gfedcba, active-high).
module code_lock_param #(
  parameter int NUM_KEYS    = 4,
  parameter int CODE_LEN    = 6,
  parameter logic [CODE_LEN*$clog2(NUM_KEYS)-1:0] DEFAULT_CODE = 12'hE48,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int LOCKOUT_CYC = 5000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                lock,
  input  logic                prog,
  output logic                unlocked,
  output logic                alarm,
  output logic [3:0]          progress,
  output logic [6:0]          position_state
);

  localparam int KW = $clog2(NUM_KEYS);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);

  localparam logic [6:0] SEG_U = 7'b0111110;
  localparam logic [6:0] SEG_L = 7'b0111000;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_OPEN,
    ST_PROG,
    ST_LOCKOUT
  } state_t;

  state_t                 r_state, w_state_nx;
  logic [NUM_KEYS-1:0]    r_keys_q;
  logic [CODE_LEN*KW-1:0] r_code, w_code_nx;
  logic [3:0]             r_progress, w_progress_nx;
  logic                   r_mismatch, w_mismatch_nx;
  logic [FW-1:0]          r_fail_cnt, w_fail_cnt_nx;
  logic [TW-1:0]          r_idle_cnt, w_idle_cnt_nx;
  logic [LW-1:0]          r_lock_cnt, w_lock_cnt_nx;

  logic                   r_unlocked, w_unlocked_nx;
  logic                   r_alarm, w_alarm_nx;
  logic [6:0]             r_seg, w_seg_nx;

  logic                   w_press;
  logic                   w_single;
  logic [KW-1:0]          w_digit;
  logic [KW-1:0]          w_code_digit;
  logic                   w_wrong;
  logic                   w_last;

  // Decimal digit in standard 7-segment encoding; blank beyond 9.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Press detection, key decode and comparison against the expected code digit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_press      = (r_keys_q == '0) && (keys != '0);
    w_single     = $onehot(keys);
    w_digit      = '0;
    w_code_digit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) w_digit = KW'(i);
    end
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_progress == 4'(i)) w_code_digit = r_code[i*KW +: KW];
    end
    w_wrong = !w_single || (w_digit != w_code_digit);
    w_last  = (r_progress == 4'(CODE_LEN - 1));
  end

  // Next-state logic for the mode FSM, code register and all counters.
  always_comb begin
    w_state_nx    = r_state;
    w_code_nx     = r_code;
    w_progress_nx = r_progress;
    w_mismatch_nx = r_mismatch;
    w_fail_cnt_nx = r_fail_cnt;
    w_idle_cnt_nx = '0;
    w_lock_cnt_nx = '0;

    case (r_state)
      ST_ENTRY: begin
        if (w_press) begin
          if (w_last) begin
            // A full code is always consumed, right or wrong, so nothing leaks about which digit failed.
            w_progress_nx = '0;
            w_mismatch_nx = 1'b0;
            if (!(r_mismatch || w_wrong)) begin
              w_state_nx    = ST_OPEN;
              w_fail_cnt_nx = '0;
            end else if (r_fail_cnt == FW'(MAX_TRIES - 1)) begin
              w_state_nx    = ST_LOCKOUT;
              w_fail_cnt_nx = FW'(MAX_TRIES);
            end else begin
              w_fail_cnt_nx = r_fail_cnt + 1'b1;
            end
          end else begin
            w_progress_nx = r_progress + 4'd1;
            w_mismatch_nx = r_mismatch | w_wrong;
          end
        end else if (r_progress != '0) begin
          // Idle counter holds the number of press-free edges already seen.
          if (r_idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
            w_progress_nx = '0;
            w_mismatch_nx = 1'b0;
          end else begin
            w_idle_cnt_nx = r_idle_cnt + 1'b1;
          end
        end
      end

      ST_OPEN: begin
        if (lock) begin
          w_state_nx = ST_ENTRY;
        end else if (prog) begin
          w_state_nx    = ST_PROG;
          w_progress_nx = '0;
        end
      end

      ST_PROG: begin
        if (lock) begin
          // Digits already written stay in the code register.
          w_state_nx    = ST_ENTRY;
          w_progress_nx = '0;
          w_mismatch_nx = 1'b0;
        end else if (w_press && w_single) begin
          for (int i = 0; i < CODE_LEN; i++) begin
            if (r_progress == 4'(i)) w_code_nx[i*KW +: KW] = w_digit;
          end
          if (w_last) begin
            w_state_nx    = ST_OPEN;
            w_progress_nx = '0;
          end else begin
            w_progress_nx = r_progress + 4'd1;
          end
        end
      end

      ST_LOCKOUT: begin
        if (r_lock_cnt == LW'(LOCKOUT_CYC - 1)) begin
          w_state_nx    = ST_ENTRY;
          w_fail_cnt_nx = '0;
        end else begin
          w_lock_cnt_nx = r_lock_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nx = ST_ENTRY;
      end
    endcase
  end

  // Registered outputs are computed from the next state so they change on the same edge.
  always_comb begin
    w_unlocked_nx = (w_state_nx == ST_OPEN) || (w_state_nx == ST_PROG);
    w_alarm_nx    = (w_state_nx == ST_LOCKOUT);
    case (w_state_nx)
      ST_OPEN:    w_seg_nx = SEG_U;
      ST_LOCKOUT: w_seg_nx = SEG_L;
      default:    w_seg_nx = seg_digit(w_progress_nx);
    endcase
  end

  // State, code, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state    <= ST_ENTRY;
      r_keys_q   <= '0;
      // NOTE: the code register is ordinary flops, so it reloads the default code on every reset.
      r_code     <= DEFAULT_CODE;
      r_progress <= '0;
      r_mismatch <= 1'b0;
      r_fail_cnt <= '0;
      r_idle_cnt <= '0;
      r_lock_cnt <= '0;
      r_unlocked <= 1'b0;
      r_alarm    <= 1'b0;
      r_seg      <= 7'b0111111;
    end else begin
      r_state    <= w_state_nx;
      r_keys_q   <= keys;
      r_code     <= w_code_nx;
      r_progress <= w_progress_nx;
      r_mismatch <= w_mismatch_nx;
      r_fail_cnt <= w_fail_cnt_nx;
      r_idle_cnt <= w_idle_cnt_nx;
      r_lock_cnt <= w_lock_cnt_nx;
      r_unlocked <= w_unlocked_nx;
      r_alarm    <= w_alarm_nx;
      r_seg      <= w_seg_nx;
    end
  end

  assign unlocked       = r_unlocked;
  assign alarm          = r_alarm;
  assign progress       = r_progress;
  assign position_state = r_seg;

endmodule

// File: tb/tb_code_lock_param.sv
// Self-checking bench for code_lock_param: an abstract model (digit queue, code array,
// countdowns) is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_code_lock_param;

  localparam int NUM_KEYS    = 4;
  localparam int CODE_LEN    = 6;
  localparam int MAX_TRIES   = 3;
  localparam int TIMEOUT_CYC = 1000;
  localparam int LOCKOUT_CYC = 5000;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       lock  = 1'b0;
  logic       prog  = 1'b0;
  logic [3:0] keys  = 4'b0000;
  logic       unlocked;
  logic       alarm;
  logic [3:0] progress;
  logic [6:0] position_state;

  int n_checks = 0;
  int n_errors = 0;

  code_lock_param #(
    .NUM_KEYS    (NUM_KEYS),
    .CODE_LEN    (CODE_LEN),
    .DEFAULT_CODE(12'hE48),
    .MAX_TRIES   (MAX_TRIES),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .LOCKOUT_CYC (LOCKOUT_CYC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .keys          (keys),
    .lock          (lock),
    .prog          (prog),
    .unlocked      (unlocked),
    .alarm         (alarm),
    .progress      (progress),
    .position_state(position_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_ENTRY, M_OPEN, M_PROG, M_LOCK} mode_t;

  logic [6:0] seg_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  mode_t      m_mode;
  int         m_code [CODE_LEN];
  int         m_entered [$];
  int         m_fails;
  int         m_idle;
  int         m_left;
  int         m_pcount;
  logic [3:0] m_prev;

  function automatic int key_digit(input logic [3:0] k);
    int d = -1;
    int n = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i]) begin
        n++;
        d = i;
      end
    end
    return (n == 1) ? d : -1;
  endfunction

  task automatic model_reset();
    m_mode   = M_ENTRY;
    m_code   = '{0, 2, 0, 1, 2, 3};
    m_entered.delete();
    m_fails  = 0;
    m_idle   = 0;
    m_left   = 0;
    m_pcount = 0;
    m_prev   = 4'b0000;
  endtask

  task automatic model_step();
    bit pressed;
    int d;
    bit ok;
    pressed = (m_prev == 4'b0000) && (keys != 4'b0000);
    d       = key_digit(keys);
    m_prev  = keys;
    case (m_mode)
      M_ENTRY: begin
        if (pressed) begin
          m_entered.push_back(d);
          m_idle = 0;
          if (m_entered.size() == CODE_LEN) begin
            ok = 1'b1;
            for (int i = 0; i < CODE_LEN; i++) if (m_entered[i] != m_code[i]) ok = 1'b0;
            m_entered.delete();
            if (ok) begin
              m_mode  = M_OPEN;
              m_fails = 0;
            end else begin
              m_fails++;
              if (m_fails >= MAX_TRIES) begin
                m_mode = M_LOCK;
                m_left = LOCKOUT_CYC;
              end
            end
          end
        end else if (m_entered.size() > 0) begin
          m_idle++;
          if (m_idle == TIMEOUT_CYC) begin
            m_entered.delete();
            m_idle = 0;
          end
        end
      end
      M_OPEN: begin
        if (lock) m_mode = M_ENTRY;
        else if (prog) begin
          m_mode   = M_PROG;
          m_pcount = 0;
        end
      end
      M_PROG: begin
        if (lock) m_mode = M_ENTRY;
        else if (pressed && d >= 0) begin
          m_code[m_pcount] = d;
          m_pcount++;
          if (m_pcount == CODE_LEN) m_mode = M_OPEN;
        end
      end
      M_LOCK: begin
        m_left--;
        if (m_left == 0) begin
          m_mode  = M_ENTRY;
          m_fails = 0;
        end
      end
      default: m_mode = M_ENTRY;
    endcase
  endtask

  function automatic int exp_progress();
    if (m_mode == M_ENTRY) return m_entered.size();
    if (m_mode == M_PROG)  return m_pcount;
    return 0;
  endfunction

  function automatic logic [6:0] exp_seg();
    if (m_mode == M_OPEN) return 7'b0111110;
    if (m_mode == M_LOCK) return 7'b0111000;
    return seg_tab[exp_progress()];
  endfunction

  // Model follows the same async reset and clock edges as the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_unlocked", unlocked, (m_mode == M_OPEN || m_mode == M_PROG) ? 1 : 0);
    check("model_alarm", alarm, (m_mode == M_LOCK) ? 1 : 0);
    check("model_progress", progress, exp_progress());
    check("model_seg", position_state, exp_seg());
  end

  // ---------------- stimulus ----------------
  int code_default [CODE_LEN] = '{0, 2, 0, 1, 2, 3};
  int code_wrong   [CODE_LEN] = '{0, 2, 1, 1, 2, 3};
  int code_new     [CODE_LEN] = '{3, 3, 2, 2, 1, 1};

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk) keys = m;
    @(negedge clk) keys = 4'b0000;
  endtask

  task automatic enter_code(input int d [CODE_LEN]);
    for (int i = 0; i < CODE_LEN; i++) press(4'(1 << d[i]));
  endtask

  task automatic do_lock();
    @(negedge clk) lock = 1'b1;
    @(negedge clk) lock = 1'b0;
  endtask

  task automatic do_prog();
    @(negedge clk) prog = 1'b1;
    @(negedge clk) prog = 1'b0;
  endtask

  initial begin
    int alarm_cycles;

    #1 reset = 1'b1;
    tick(3);
    check("reset_unlocked", unlocked, 0);
    check("reset_alarm", alarm, 0);
    check("reset_progress", progress, 0);
    check("reset_seg", position_state, 7'b0111111);
    reset = 1'b0;

    // Default code with per-digit progress.
    for (int i = 0; i < CODE_LEN; i++) begin
      press(4'(1 << code_default[i]));
      if (i < CODE_LEN - 1) check("entry_progress", progress, i + 1);
    end
    check("default_unlocked", unlocked, 1);
    check("default_seg_u", position_state, 7'b0111110);
    check("default_progress", progress, 0);
    do_lock();
    check("relock_unlocked", unlocked, 0);
    check("relock_seg", position_state, 7'b0111111);

    // Wrong third digit: full entry consumed, stays locked (fail 1).
    enter_code(code_wrong);
    check("wrong_unlocked", unlocked, 0);
    check("wrong_progress", progress, 0);

    // Two keys at once as second digit counts as a wrong digit (fail 2).
    press(4'b0001);
    press(4'b0101);
    check("multi_progress", progress, 2);
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    press(4'b1000);
    check("multi_unlocked", unlocked, 0);
    check("multi_alarm", alarm, 0);

    // Third failure: lockout for exactly LOCKOUT_CYC cycles.
    enter_code(code_wrong);
    check("lockout_alarm", alarm, 1);
    check("lockout_seg_l", position_state, 7'b0111000);
    alarm_cycles = 0;
    while (alarm === 1'b1 && alarm_cycles < LOCKOUT_CYC + 1000) begin
      alarm_cycles++;
      @(negedge clk);
    end
    check("lockout_length", alarm_cycles, 5000);
    check("lockout_exit_seg", position_state, 7'b0111111);
    enter_code(code_default);
    check("after_lockout_unlocked", unlocked, 1);
    do_lock();

    // Key 0 to key 1 with no zero gap is a single press.
    @(negedge clk) keys = 4'b0001;
    @(negedge clk) keys = 4'b0010;
    @(negedge clk) keys = 4'b0000;
    check("nogap_progress", progress, 1);
    for (int i = 1; i < CODE_LEN; i++) press(4'(1 << code_default[i]));
    check("nogap_unlocked", unlocked, 1);
    do_lock();

    // Timeout: one failure first, then a timed-out entry must not add another.
    enter_code(code_wrong);
    press(4'b0001);
    press(4'b0100);
    check("timeout_start", progress, 2);
    tick(TIMEOUT_CYC - 1);
    check("timeout_before", progress, 2);
    tick(1);
    check("timeout_after", progress, 0);
    enter_code(code_wrong);
    check("timeout_no_lockout", alarm, 0);
    enter_code(code_default);
    check("timeout_unlocked", unlocked, 1);

    // Reprogram to 3,3,2,2,1,1; a two-key press during programming is ignored.
    do_prog();
    check("prog_unlocked", unlocked, 1);
    check("prog_seg", position_state, 7'b0111111);
    for (int i = 0; i < CODE_LEN; i++) begin
      press(4'(1 << code_new[i]));
      if (i == 1) begin
        press(4'b0011);
        check("prog_multi_ignored", progress, 2);
      end
    end
    check("prog_done_seg_u", position_state, 7'b0111110);
    check("prog_done_unlocked", unlocked, 1);
    do_lock();
    enter_code(code_default);
    check("old_code_rejected", unlocked, 0);
    enter_code(code_new);
    check("new_code_unlocked", unlocked, 1);

    // Reset mid-programming restores the default code.
    do_prog();
    press(4'b0100);
    press(4'b1000);
    check("midprog_progress", progress, 2);
    #2 reset = 1'b1;
    #1;
    check("midprog_reset_unlocked", unlocked, 0);
    check("midprog_reset_progress", progress, 0);
    check("midprog_reset_seg", position_state, 7'b0111111);
    tick(2);
    reset = 1'b0;
    enter_code(code_default);
    check("midprog_default_unlocked", unlocked, 1);
    do_lock();

    // Reset mid-lockout.
    enter_code(code_wrong);
    enter_code(code_wrong);
    enter_code(code_wrong);
    tick(100);
    check("midlock_alarm", alarm, 1);
    #2 reset = 1'b1;
    #1;
    check("midlock_reset_alarm", alarm, 0);
    check("midlock_reset_seg", position_state, 7'b0111111);
    tick(2);
    reset = 1'b0;
    enter_code(code_default);
    check("midlock_default_unlocked", unlocked, 1);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
